obi_mem_arbiter: RTL and testbench

- Two-master to one-slave OBI arbiter in front of the testbench memory model's data port.
- Master 0 is the core data interface; master 1 is the debug module system-bus master.
- Round-robin arbitration with request locking, so an ungranted request is never withdrawn or switched.
- An in-order ID FIFO routes each slave response (rvalid/rdata) back to the master that issued it, with up to MAX_OUTSTANDING transactions in flight.

---
 rtl/obi_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// Two-master to one-slave OBI arbiter with round-robin selection, request locking
// and an in-order ID FIFO that steers each slave response back to its issuing master.
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_mem_q [MAX_OUTSTANDING];

  logic sel;
  logic sel_req;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic push;
  logic pop;
  logic head_id;
  logic rsp_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);

  // rr_q holds the id granted last; the other master wins a tie.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = ~rr_q;
    end else if (m1_req_i) begin
      sel = 1'b1;
    end
  end

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign s_req_o   = sel_req & ~fifo_full & ~rst_i;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  assign accept   = s_req_o & s_gnt_i;
  assign m0_gnt_o = accept & ~sel;
  assign m1_gnt_o = accept & sel;

  assign push      = accept;
  assign pop       = s_rvalid_i & ~fifo_empty;
  assign head_id   = id_mem_q[rd_ptr_q];
  assign rsp_valid = pop & ~rst_i;

  assign m0_rvalid_o = rsp_valid & ~head_id;
  assign m1_rvalid_o = rsp_valid & head_id;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = err_q;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (s_req_o) begin
      // Presented but not granted: pin the selection until the slave takes it.
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
  end

  always_comb begin
    rr_d     = accept ? sel : rr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    err_d = err_q | (s_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      rr_q      <= 1'b1;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the arbiter.
module tb_obi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_v   [2];
  logic [AW-1:0] addr_v  [2];
  logic          we_v    [2];
  logic [BW-1:0] be_v    [2];
  logic [DW-1:0] wdata_v [2];
  logic          s_gnt_i;
  logic          s_rvalid_i;
  logic [DW-1:0] s_rdata_i;

  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_we_o, err_o;
  logic [AW-1:0] s_addr_o;
  logic [BW-1:0] s_be_o;
  logic [DW-1:0] s_wdata_o;

  always #5 clk_i = ~clk_i;

  obi_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(req_v[0]), .m0_gnt_o(m0_gnt_o), .m0_addr_i(addr_v[0]), .m0_we_i(we_v[0]),
    .m0_be_i(be_v[0]), .m0_wdata_i(wdata_v[0]), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(req_v[1]), .m1_gnt_o(m1_gnt_o), .m1_addr_i(addr_v[1]), .m1_we_i(we_v[1]),
    .m1_be_i(be_v[1]), .m1_wdata_i(wdata_v[1]), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .err_o(err_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: ids of issued-but-unanswered transactions in issue order,
  // the id granted last, and the id whose presented request is still waiting.
  int q[$];
  int last_gnt = 1;
  int stalled  = -1;
  bit err_m    = 1'b0;

  int e_sel;
  bit e_sreq;
  bit e_acc;
  int e_rv_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    #4;
    e_sel = 0; e_sreq = 1'b0; e_acc = 1'b0; e_rv_id = -1;
    if (rst_i) begin
      chk("rst_s_req", s_req_o, 0);
      chk("rst_m0_gnt", m0_gnt_o, 0);
      chk("rst_m1_gnt", m1_gnt_o, 0);
      chk("rst_m0_rvalid", m0_rvalid_o, 0);
      chk("rst_m1_rvalid", m1_rvalid_o, 0);
    end else begin
      if (stalled >= 0) e_sel = stalled;
      else if (req_v[0] && req_v[1]) e_sel = 1 - last_gnt;
      else e_sel = req_v[1] ? 1 : 0;
      e_sreq  = req_v[e_sel] && (q.size() < MO);
      e_acc   = e_sreq && s_gnt_i;
      e_rv_id = (s_rvalid_i && q.size() > 0) ? q[0] : -1;
      chk("s_req", s_req_o, e_sreq);
      chk("m0_gnt", m0_gnt_o, e_acc && e_sel == 0);
      chk("m1_gnt", m1_gnt_o, e_acc && e_sel == 1);
      chk("m0_rvalid", m0_rvalid_o, e_rv_id == 0);
      chk("m1_rvalid", m1_rvalid_o, e_rv_id == 1);
      chk("err", err_o, err_m);
      if (e_sreq) begin
        chk("s_addr", s_addr_o, addr_v[e_sel]);
        chk("s_we", s_we_o, we_v[e_sel]);
        chk("s_be", s_be_o, be_v[e_sel]);
        chk("s_wdata", s_wdata_o, wdata_v[e_sel]);
      end
      if (e_rv_id == 0) chk("m0_rdata", m0_rdata_o, s_rdata_i);
      if (e_rv_id == 1) chk("m1_rdata", m1_rdata_o, s_rdata_i);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (rst_i) begin
      q.delete();
      last_gnt = 1;
      stalled  = -1;
      err_m    = 1'b0;
    end else begin
      if (s_rvalid_i) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (e_acc) begin
        q.push_back(e_sel);
        last_gnt = e_sel;
        stalled  = -1;
      end else if (e_sreq) begin
        stalled = e_sel;
      end
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic [AW-1:0] a);
    req_v[i]   = r;
    addr_v[i]  = a;
    we_v[i]    = 1'($urandom_range(0, 1));
    be_v[i]    = BW'($urandom);
    wdata_v[i] = $urandom;
  endtask

  task automatic idle_slave();
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
  endtask

  task automatic drain();
    int n = 0;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    s_gnt_i = 1'b0;
    while (q.size() > 0 && n < 16) begin
      s_rvalid_i = 1'b1; s_rdata_i = $urandom;
      eval(); advance();
      n++;
    end
    idle_slave();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_slave();
    eval(); advance();
    eval(); advance();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    idle_slave();
    @(posedge clk_i); #1;
    do_reset();
    eval();
    chk("reset_err", err_o, 0);
    chk("reset_s_req", s_req_o, 0);
    advance();

    // m0 read at 0x100, granted at once, answered one cycle later
    set_req(0, 1'b1, 32'h100); we_v[0] = 1'b0;
    s_gnt_i = 1'b1;
    eval();
    chk("tp1_m0_gnt", m0_gnt_o, 1);
    chk("tp1_m1_gnt", m1_gnt_o, 0);
    chk("tp1_addr", s_addr_o, 32'h100);
    advance();
    req_v[0] = 1'b0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    eval();
    chk("tp1_m0_rvalid", m0_rvalid_o, 1);
    chk("tp1_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
    chk("tp1_m1_rvalid", m1_rvalid_o, 0);
    advance();
    idle_slave();

    // both masters stream, slave always grants: strict alternation
    do_reset();
    set_req(0, 1'b1, 32'h1000);
    set_req(1, 1'b1, 32'h2000);
    s_gnt_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_rvalid_i = (k > 0); s_rdata_i = $urandom;
      eval();
      chk("tp2_m0_gnt", m0_gnt_o, (k % 2) == 0);
      chk("tp2_m1_gnt", m1_gnt_o, (k % 2) == 1);
      if (k > 0) chk("tp2_m1_rvalid", m1_rvalid_o, (k % 2) == 0);
      advance();
    end
    drain();

    // m1 stalled by the slave while m0 also requests: m1 must stay selected
    set_req(0, 1'b0, 32'h1000);
    set_req(1, 1'b1, 32'h2000);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) req_v[0] = 1'b1;
      if (k == 4) req_v[1] = 1'b0;
      s_gnt_i = (k >= 3);
      eval();
      if (k < 4) chk("tp3_addr_m1", s_addr_o, 32'h2000);
      chk("tp3_m1_gnt", m1_gnt_o, k == 3);
      chk("tp3_m0_gnt", m0_gnt_o, k == 4);
      advance();
    end
    drain();

    // FIFO full blocks a third request, even in the cycle its rvalid arrives
    set_req(0, 1'b1, 32'h300);
    s_gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_rvalid_i = (k == 3); s_rdata_i = $urandom;
      eval();
      chk("tp4_s_req", s_req_o, (k < 2) || (k == 4));
      if (k == 3) chk("tp4_m0_rvalid", m0_rvalid_o, 1);
      advance();
    end
    drain();

    // stray rvalid with nothing outstanding
    s_rvalid_i = 1'b1; s_rdata_i = 32'h55AA55AA;
    eval();
    chk("tp5_m0_rvalid", m0_rvalid_o, 0);
    chk("tp5_m1_rvalid", m1_rvalid_o, 0);
    advance();
    idle_slave();
    for (int k = 0; k < 4; k++) begin
      eval();
      chk("tp5_err_sticky", err_o, 1);
      advance();
    end

    // reset with one outstanding and m0 locked
    set_req(1, 1'b1, 32'h2400);
    s_gnt_i = 1'b1;
    eval(); advance();
    req_v[1] = 1'b0;
    set_req(0, 1'b1, 32'h400);
    s_gnt_i = 1'b0;
    eval(); advance();
    do_reset();
    set_req(1, 1'b1, 32'h2400);
    s_gnt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      eval();
      if (k == 0) chk("tp6_err_clr", err_o, 0);
      chk("tp6_m0_gnt", m0_gnt_o, k == 0);
      chk("tp6_m1_gnt", m1_gnt_o, k == 1);
      chk("tp6_full", s_req_o, k < 2);
      advance();
    end
    drain();

    // random traffic with a compliant slave (rvalid only for earlier grants)
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        if (!req_v[i] && $urandom_range(0, 2) == 0) set_req(i, 1'b1, $urandom);
      s_gnt_i    = ($urandom_range(0, 3) != 0);
      s_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata_i  = $urandom;
      eval();
      advance();
      for (int i = 0; i < 2; i++)
        if (req_v[i] && e_acc && e_sel == i) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 1'b1, $urandom);
          else req_v[i] = 1'b0;
        end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
